// File: rtl/xslide_pkg.sv
// Shared helpers for the sliding-window block: width derivation and sample extension.
package xslide_pkg;

    localparam int DEF_BWID  = 16;
    localparam int DEF_NCH   = 8;
    localparam int DEF_NWMAX = 64;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int clog2(input int unsigned n);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r = r + 1;
        return r;
    endfunction

    // Same as clog2 but never returns 0, so a single-entry field still has one bit.
    function automatic int clog2_min1(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // Sign- or zero-extend the low bw bits of v to 64 bits; callers truncate to their width.
    function automatic logic [63:0] ext64(input logic [63:0] v, input int unsigned bw,
                                          input bit sgn);
        logic [63:0] m;
        m = (64'd1 << bw) - 64'd1;
        if (sgn && v[6'(bw - 1)]) return v | ~m;
        else return v & m;
    endfunction

endpackage

// File: rtl/xsdpram_rf.sv
// Simple dual-port sample RAM: one write port, one registered read port, read-first.
module xsdpram_rf
    import xslide_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 9,
    parameter int DEPTH = 512
)(
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Read returns the pre-write contents when both ports hit the same address.
    always_ff @(posedge clk) begin
        rdata_o <= mem_q[raddr_i];
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

endmodule

// File: rtl/xslidewin_mc.sv
// Multi-channel time-interleaved sliding-window sum and mean with runtime power-of-two window.
// Pipeline: input register (S1), accumulator/old-sample fetch (S2), sum register (S3), output.
module xslidewin_mc
    import xslide_pkg::*;
#(
    parameter int BWID   = DEF_BWID,
    parameter int NCH    = DEF_NCH,
    parameter int NWMAX  = DEF_NWMAX,
    parameter bit SIGNED = 1'b1,
    localparam int CHW   = clog2_min1(NCH),
    localparam int LOGW  = clog2(NWMAX),
    localparam int WLW   = clog2_min1(LOGW + 1)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BWID-1:0]      iDin,
    input  logic [CHW-1:0]       iCh,
    input  logic                 iND,
    input  logic [WLW-1:0]       iWinLog2,
    input  logic                 iClr,
    output logic [BWID+LOGW-1:0] oDout,
    output logic [BWID-1:0]      oMean,
    output logic [CHW-1:0]       oCh,
    output logic                 oFull,
    output logic                 oDV
);

    localparam int SW = BWID + LOGW;
    localparam int FW = LOGW + 1;
    localparam int AW = CHW + LOGW;
    localparam logic [WLW-1:0] LOGW_C = WLW'(LOGW);

    logic [WLW-1:0]  wl_q, wl_d;
    logic            clr_d, accept_d;

    logic            s1_vld_q;
    logic [CHW-1:0]  s1_ch_q;
    logic [BWID-1:0] s1_din_q;
    logic [WLW-1:0]  s1_wl_q;

    logic            s2_vld_q;
    logic [CHW-1:0]  s2_ch_q;
    logic [BWID-1:0] s2_din_q;
    logic [WLW-1:0]  s2_wl_q;
    logic [SW-1:0]   s2_acc_q;
    logic [FW-1:0]   s2_fill_q;

    logic            s3_vld_q;
    logic [SW-1:0]   s3_sum_q;
    logic [CHW-1:0]  s3_ch_q;
    logic [WLW-1:0]  s3_wl_q;
    logic            s3_full_q;

    logic [SW-1:0]   acc_q  [NCH];
    logic [FW-1:0]   fill_q [NCH];
    logic [LOGW-1:0] wptr_q [NCH];

    logic [BWID-1:0] old_rd;
    logic            ram_we_d;
    logic [AW-1:0]   ram_waddr_d, ram_raddr_d;
    logic [FW-1:0]   s1_w_d, s2_w_d, fill_d;
    logic            s2_full_d, fwd_d;
    logic [SW-1:0]   sum_d;
    logic [BWID-1:0] mean_d;

    xsdpram_rf #(
        .DW    (BWID),
        .AW    (AW),
        .DEPTH (NCH * NWMAX)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_d),
        .waddr_i (ram_waddr_d),
        .wdata_i (s1_din_q),
        .raddr_i (ram_raddr_d),
        .rdata_o (old_rd)
    );

    // Window clamp, clear detection, RAM addressing, window arithmetic and forwarding select.
    always_comb begin
        wl_d        = (iWinLog2 > LOGW_C) ? LOGW_C : iWinLog2;
        clr_d       = iClr | (wl_d != wl_q);
        accept_d    = iND & (32'(iCh) < NCH);
        s1_w_d      = FW'(1) << s1_wl_q;
        ram_we_d    = s1_vld_q & ~clr_d;
        ram_waddr_d = {s1_ch_q, wptr_q[s1_ch_q]};
        // At W=NWMAX the read and write addresses coincide; the RAM hands back the old sample.
        ram_raddr_d = {s1_ch_q, wptr_q[s1_ch_q] - LOGW'(s1_w_d)};
        s2_w_d      = FW'(1) << s2_wl_q;
        s2_full_d   = (s2_fill_q == s2_w_d);
        sum_d       = s2_acc_q + SW'(ext64(64'(s2_din_q), BWID, SIGNED));
        if (s2_full_d) sum_d = sum_d - SW'(ext64(64'(old_rd), BWID, SIGNED));
        fill_d      = s2_full_d ? s2_w_d : s2_fill_q + FW'(1);
        fwd_d       = s2_vld_q & (s2_ch_q == s1_ch_q);
        if (SIGNED) mean_d = BWID'($signed(s3_sum_q) >>> s3_wl_q);
        else        mean_d = BWID'(s3_sum_q >> s3_wl_q);
    end

    // Pipeline stages plus the per-channel accumulator, fill and write-pointer state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wl_q      <= wl_d;
            s1_vld_q  <= 1'b0;
            s1_ch_q   <= '0;
            s1_din_q  <= '0;
            s1_wl_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_ch_q   <= '0;
            s2_din_q  <= '0;
            s2_wl_q   <= '0;
            s2_acc_q  <= '0;
            s2_fill_q <= '0;
            s3_vld_q  <= 1'b0;
            s3_sum_q  <= '0;
            s3_ch_q   <= '0;
            s3_wl_q   <= '0;
            s3_full_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= '0;
                fill_q[i] <= '0;
                wptr_q[i] <= '0;
            end
        end else begin
            wl_q     <= wl_d;
            s1_vld_q <= accept_d & ~clr_d;
            if (accept_d) begin
                s1_ch_q  <= iCh;
                s1_din_q <= iDin;
            end
            s1_wl_q   <= wl_d;

            s2_vld_q  <= s1_vld_q & ~clr_d;
            s2_ch_q   <= s1_ch_q;
            s2_din_q  <= s1_din_q;
            s2_wl_q   <= s1_wl_q;
            s2_acc_q  <= fwd_d ? sum_d  : acc_q[s1_ch_q];
            s2_fill_q <= fwd_d ? fill_d : fill_q[s1_ch_q];
            if (ram_we_d) wptr_q[s1_ch_q] <= wptr_q[s1_ch_q] + LOGW'(1);

            s3_vld_q  <= s2_vld_q & ~clr_d;
            s3_sum_q  <= sum_d;
            s3_ch_q   <= s2_ch_q;
            s3_wl_q   <= s2_wl_q;
            s3_full_q <= (fill_d == s2_w_d);

            if (clr_d) begin
                for (int i = 0; i < NCH; i++) begin
                    acc_q[i]  <= '0;
                    fill_q[i] <= '0;
                end
            end else if (s2_vld_q) begin
                acc_q[s2_ch_q]  <= sum_d;
                fill_q[s2_ch_q] <= fill_d;
            end
        end
    end

    // Output register; a clear does not retract the result already in S3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oDV   <= 1'b0;
            oDout <= '0;
            oMean <= '0;
            oCh   <= '0;
            oFull <= 1'b0;
        end else begin
            oDV <= s3_vld_q;
            if (s3_vld_q) begin
                oDout <= s3_sum_q;
                oMean <= mean_d;
                oCh   <= s3_ch_q;
                oFull <= s3_full_q;
            end
        end
    end

endmodule

// File: tb/tb_xslidewin_mc.sv
// Self-checking bench for xslidewin_mc: sample-history reference model, vector table, corner sequences.
module tb_xslidewin_mc;

    localparam int BWID  = 16;
    localparam int NCH   = 6;
    localparam int NWMAX = 64;
    localparam int LOGW  = 6;
    localparam int CHW   = 3;
    localparam int WLW   = 3;
    localparam int SW    = BWID + LOGW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [BWID-1:0] iDin;
    logic [CHW-1:0]  iCh;
    logic            iND;
    logic [WLW-1:0]  iWinLog2;
    logic            iClr;
    logic [SW-1:0]   oDout;
    logic [BWID-1:0] oMean;
    logic [CHW-1:0]  oCh;
    logic            oFull;
    logic            oDV;

    always #5 clk = ~clk;

    xslidewin_mc #(.BWID(BWID), .NCH(NCH), .NWMAX(NWMAX), .SIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .iDin(iDin), .iCh(iCh), .iND(iND),
        .iWinLog2(iWinLog2), .iClr(iClr), .oDout(oDout), .oMean(oMean),
        .oCh(oCh), .oFull(oFull), .oDV(oDV)
    );

    typedef struct {int due; int ch; int sum; int mean; int full;} exp_t;
    typedef struct {int ch; int sum; int mean; int full;} beat_t;
    typedef struct {int din; int sum; int mean; int full;} vec_t;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    exp_t  exp_q[$];
    beat_t got_q[$];
    int    hist [NCH][NWMAX];
    int    nsamp [NCH];
    int    wl_m;

    function automatic int clampw(input int v);
        return (v > LOGW) ? LOGW : v;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Model: every accepted sample's result is the plain sum of the last min(n,W) samples of its channel.
    task automatic model_edge();
        int ch, w, m, s;
        exp_t e;
        if (!rst_n) begin
            while (exp_q.size() > 0 && exp_q[$].due >= cyc) void'(exp_q.pop_back());
            for (int i = 0; i < NCH; i++) nsamp[i] = 0;
            wl_m = clampw(int'(iWinLog2));
        end else if (iClr || clampw(int'(iWinLog2)) != wl_m) begin
            while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
            for (int i = 0; i < NCH; i++) nsamp[i] = 0;
            wl_m = clampw(int'(iWinLog2));
        end else if (iND && int'(iCh) < NCH) begin
            ch = int'(iCh);
            hist[ch][nsamp[ch] % NWMAX] = int'($signed(iDin));
            nsamp[ch]++;
            w = 1 << wl_m;
            m = (nsamp[ch] < w) ? nsamp[ch] : w;
            s = 0;
            for (int k = 0; k < m; k++) s += hist[ch][(nsamp[ch] - 1 - k) % NWMAX];
            e.due  = cyc + 3;
            e.ch   = ch;
            e.sum  = s;
            e.mean = s >>> wl_m;
            e.full = (nsamp[ch] >= w) ? 1 : 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_out();
        exp_t  e;
        beat_t b;
        logic [SW-1:0]   xs;
        logic [BWID-1:0] xm;
        if (oDV) begin
            b.ch   = int'(oCh);
            b.sum  = int'($signed(oDout));
            b.mean = int'($signed(oMean));
            b.full = int'(oFull);
            got_q.push_back(b);
            checks++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e  = exp_q.pop_front();
                xs = SW'(e.sum);
                xm = BWID'(e.mean);
                if (oDout !== xs || oMean !== xm || int'(oCh) != e.ch || int'(oFull) != e.full) begin
                    failures++;
                    $display("FAIL beat cyc=%0d got dout=%0d mean=%0d ch=%0d full=%0d want dout=%0d mean=%0d ch=%0d full=%0d",
                             cyc, b.sum, b.mean, b.ch, b.full, e.sum, e.mean, e.ch, e.full);
                end
            end else begin
                failures++;
                $display("FAIL unexpected_dv cyc=%0d got dout=%0d ch=%0d want no output", cyc, b.sum, b.ch);
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            checks++;
            failures++;
            e = exp_q.pop_front();
            $display("FAIL missing_dv cyc=%0d got none want dout=%0d ch=%0d", cyc, e.sum, e.ch);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_out();
    endtask

    task automatic drive(input bit nd, input int ch, input int d, input bit clr);
        iND  = nd;
        iCh  = CHW'(ch);
        iDin = BWID'(d);
        iClr = clr;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_dout"}, int'(oDout), 0);
        chk({tag, "_mean"}, int'(oMean), 0);
        chk({tag, "_ch"},   int'(oCh),   0);
        chk({tag, "_full"}, int'(oFull), 0);
        chk({tag, "_dv"},   int'(oDV),   0);
    endtask

    vec_t tv [8];

    initial begin
        tv[0] = '{1,  1, 0, 0};
        tv[1] = '{2,  3, 0, 0};
        tv[2] = '{3,  6, 1, 0};
        tv[3] = '{4, 10, 2, 1};
        tv[4] = '{5, 14, 3, 1};
        tv[5] = '{6, 18, 4, 1};
        tv[6] = '{7, 22, 5, 1};
        tv[7] = '{8, 26, 6, 1};

        rst_n = 1'b0; iND = 1'b0; iCh = '0; iDin = '0; iWinLog2 = 3'd2; iClr = 1'b0;
        tick();
        tick();
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // W=4, channel 0, inputs 1..8 from the vector table
        got_q.delete();
        for (int i = 0; i < 8; i++) drive(1'b1, 0, tv[i].din, 1'b0);
        idle(4);
        chk("t1_nbeats", got_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("t1_sum%0d", i),  got_q[i].sum,  tv[i].sum);
                chk($sformatf("t1_mean%0d", i), got_q[i].mean, tv[i].mean);
                chk($sformatf("t1_full%0d", i), got_q[i].full, tv[i].full);
                chk($sformatf("t1_ch%0d", i),   got_q[i].ch,   0);
            end
        end

        // W=64, ch0/ch1 interleaved with +100/-100
        iWinLog2 = 3'd6;
        idle(1);
        got_q.delete();
        for (int i = 0; i < 140; i++) drive(1'b1, i % 2, (i % 2 != 0) ? -100 : 100, 1'b0);
        idle(4);
        chk("t2_nbeats", got_q.size(), 140);
        if (got_q.size() == 140) begin
            chk("t2_full63", got_q[124].full, 0);
            chk("t2_full64", got_q[126].full, 1);
            chk("t2_ch0_sum", got_q[138].sum, 6400);
            chk("t2_ch0_mean", got_q[138].mean, 100);
            chk("t2_ch1_sum", got_q[139].sum, -6400);
            chk("t2_ch1_mean", got_q[139].mean, -100);
            chk("t2_ch1_full", got_q[139].full, 1);
        end

        // Same channel every clock at W=NWMAX, random data
        for (int i = 0; i < 1000; i++) drive(1'b1, 5, int'($urandom_range(0, 65535)), 1'b0);
        idle(4);

        // Clear with a sample presented and two in flight
        iWinLog2 = 3'd2;
        idle(1);
        got_q.delete();
        drive(1'b1, 2, 10, 1'b0);
        drive(1'b1, 2, 20, 1'b0);
        drive(1'b1, 2, 30, 1'b0);
        drive(1'b1, 2, 40, 1'b0);
        drive(1'b1, 2, 50, 1'b1);
        drive(1'b1, 2, 60, 1'b0);
        idle(5);
        chk("t4_nbeats", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("t4_sum0", got_q[0].sum, 10);
            chk("t4_sum1", got_q[1].sum, 30);
            chk("t4_after_clr_sum", got_q[2].sum, 60);
            chk("t4_after_clr_full", got_q[2].full, 0);
        end

        // Window change 16 -> 4 while streaming
        iWinLog2 = 3'd4;
        idle(1);
        got_q.delete();
        for (int i = 0; i < 20; i++) drive(1'b1, 3, i + 1, 1'b0);
        iWinLog2 = 3'd2;
        drive(1'b1, 3, 99, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 3, 3, 1'b0);
        idle(4);
        chk("t5_nbeats", got_q.size(), 28);
        if (got_q.size() == 28) begin
            chk("t5_w16_sum", got_q[17].sum, 168);
            chk("t5_w16_mean", got_q[17].mean, 10);
            chk("t5_first_sum", got_q[18].sum, 3);
            chk("t5_first_full", got_q[18].full, 0);
            chk("t5_last_sum", got_q[27].sum, 12);
            chk("t5_last_mean", got_q[27].mean, 3);
            chk("t5_last_full", got_q[27].full, 1);
        end

        // Out-of-range window code clamps to NWMAX
        iWinLog2 = 3'd7;
        idle(1);
        got_q.delete();
        for (int i = 0; i < 70; i++) drive(1'b1, 4, 2, 1'b0);
        idle(4);
        chk("t5b_nbeats", got_q.size(), 70);
        if (got_q.size() == 70) begin
            chk("t5b_full63", got_q[62].full, 0);
            chk("t5b_full64", got_q[63].full, 1);
            chk("t5b_sum64", got_q[63].sum, 128);
            chk("t5b_mean64", got_q[63].mean, 2);
            chk("t5b_sum70", got_q[69].sum, 128);
        end

        // Mid-stream reset, then out-of-range channel tags
        for (int i = 0; i < 10; i++) drive(1'b1, 0, int'($urandom_range(0, 65535)), 1'b0);
        rst_n = 1'b0;
        drive(1'b1, 0, 1234, 1'b0);
        rst_n = 1'b1;
        chk_zero_outputs("t6_rst");
        got_q.delete();
        for (int i = 0; i < 6; i++) drive(1'b1, 6 + (i % 2), 500 + i, 1'b0);
        idle(4);
        chk("t6_oor_nbeats", got_q.size(), 0);
        chk_zero_outputs("t6_oor");
        for (int i = 0; i < 8; i++) drive(1'b1, 1, 7 * i - 20, 1'b0);
        idle(4);

        // Random traffic: channels incl. out-of-range, gaps, clears, window changes
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 149) == 0) iWinLog2 = WLW'($urandom_range(0, 7));
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 65535)), $urandom_range(0, 63) == 0);
        end
        idle(5);
        chk("final_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
